// File: rtl/rom_1p_arb.sv
// rom_1p_arb: round-robin arbiter sharing one single-port ROM among Req_Num requesters.
// Define ROM_1P_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module rom_1p_arb #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8,
    parameter int Req_Num    = 4,
    parameter int Id_Width   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [Req_Num-1:0]             req_i,
    input  logic [Req_Num*Addr_Width-1:0]  addr_i,
    output logic [Req_Num-1:0]             gnt_o,
    output logic [Word_Width-1:0]          rdata_o,
    output logic [Id_Width-1:0]            rid_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic                           rom_cen_o,
    output logic                           rom_oen_o,
    output logic [Addr_Width-1:0]          rom_addr_o,
    input  logic [Word_Width-1:0]          rom_data_i
);
    typedef enum logic [1:0] {IDLE, RD, WT, VLD} state_t;
    state_t state, nxt;
    logic [Id_Width-1:0] win, cur_id;
    logic go_rd;
    logic [Req_Num-1:0] gnt_d;
    logic [Addr_Width-1:0] addr_d;
`ifndef ROM_1P_ARB_FIXED_PRI_EN
    logic [Id_Width-1:0] ptr;
`endif

    // Scan in reverse search order so the first asserted request overwrites the rest.
    always_comb begin
        win = '0;
`ifdef ROM_1P_ARB_FIXED_PRI_EN
        for (int k = Req_Num - 1; k >= 0; k--)
            if (req_i[k]) win = Id_Width'(k);
`else
        for (int i = Req_Num; i >= 1; i--) begin
            int j;
            j = (int'(ptr) + i) % Req_Num;
            if (req_i[j]) win = Id_Width'(j);
        end
`endif
    end

    always_comb begin
        go_rd = |req_i && (state == IDLE || (state == VLD && rready_i));
        nxt = go_rd ? RD :
              state == RD ? WT :
              state == WT ? VLD :
              (state == VLD && rready_i) ? IDLE : state;
    end

    always_comb begin
        gnt_d  = go_rd ? {{(Req_Num-1){1'b0}}, 1'b1} << win : '0;
        addr_d = addr_i[win*Addr_Width +: Addr_Width];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_o      <= '0;
            rvalid_o   <= 1'b0;
            rdata_o    <= '0;
            rid_o      <= '0;
            rom_cen_o  <= 1'b1;
            rom_oen_o  <= 1'b1;
            rom_addr_o <= '0;
            cur_id     <= '0;
`ifndef ROM_1P_ARB_FIXED_PRI_EN
            ptr        <= Id_Width'(Req_Num - 1);
`endif
        end else begin
            state     <= nxt;
            gnt_o     <= gnt_d;
            rom_cen_o <= ~go_rd;
            rom_oen_o <= 1'b0;
            rvalid_o  <= nxt == VLD;
            if (go_rd) begin
                rom_addr_o <= addr_d;
                cur_id     <= win;
`ifndef ROM_1P_ARB_FIXED_PRI_EN
                ptr        <= win;
`endif
            end
            if (state == WT) begin
                rdata_o <= rom_data_i;
                rid_o   <= cur_id;
            end
        end
    end
endmodule

// File: tb/tb_rom_1p_arb.sv
// tb_rom_1p_arb: directed bench for rom_1p_arb with a behavioural 1-cycle-latency ROM.
module tb_rom_1p_arb;
    logic        clk = 0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        rvalid, rready, cen, oen;
    logic [7:0]  raddr;
    logic [31:0] rom_data = '0;
    logic [31:0] mem [256];
    int n_chk = 0, n_err = 0;
    int id;
    logic [3:0] eg;
`ifdef ROM_1P_ARB_FIXED_PRI_EN
    localparam bit fp = 1;
`else
    localparam bit fp = 0;
`endif

    rom_1p_arb dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt),
        .rdata_o(rdata), .rid_o(rid), .rvalid_o(rvalid), .rready_i(rready),
        .rom_cen_o(cen), .rom_oen_o(oen), .rom_addr_o(raddr), .rom_data_i(rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!cen) rom_data <= mem[raddr];

    function automatic logic [31:0] romv(input int a);
        return a == 8'h3C ? 32'hDEADBEEF : 32'hA5C3E100 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = romv(a);
        rst_n = 0; req = 4'b1111; rready = 1;
        addr = {8'h13, 8'h12, 8'h11, 8'h10};
        step; step;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_cen", cen, 1);
        chk("rst_oen", oen, 1);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            step;
            id = fp ? 0 : k % 4;
            eg = 4'b0001 << id;
            chk("rr_gnt", gnt, eg);
            chk("rr_cen", cen, 0);
            chk("rr_addr", raddr, 8'h10 + id);
            chk("rr_oen", oen, 0);
            step;
            chk("wt_cen", cen, 1);
            chk("wt_gnt", gnt, 0);
            step;
            chk("rr_rvalid", rvalid, 1);
            chk("rr_rdata", rdata, romv(8'h10 + id));
            chk("rr_rid", rid, id);
        end
        rready = 0;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, romv(8'h10));
            chk("bp_rid", rid, 0);
            chk("bp_gnt", gnt, 0);
            chk("bp_cen", cen, 1);
        end
        rready = 1;
        step;
        id = fp ? 0 : 1;
        eg = 4'b0001 << id;
        chk("bp_next_gnt", gnt, eg);
        req = 0;
        step; step;
        chk("bp_next_rid", rid, id);
        chk("bp_next_rdata", rdata, romv(8'h10 + id));
        step;
        chk("idle_rvalid", rvalid, 0);
        addr[23:16] = 8'h3C; req = 4'b0100;
        step;
        chk("sr_gnt", gnt, 4'b0100);
        chk("sr_cen", cen, 0);
        chk("sr_addr", raddr, 8'h3C);
        req = 0;
        step; step;
        chk("sr_rvalid", rvalid, 1);
        chk("sr_rdata", rdata, 32'hDEADBEEF);
        chk("sr_rid", rid, 2);
        step;
        req = 4'b0100;
        step;
        chk("mr_gnt", gnt, 4'b0100);
        req = 0;
        step;
        rst_n = 0;
        step;
        chk("mr_rvalid", rvalid, 0);
        chk("mr_cen", cen, 1);
        rst_n = 1;
        step; step;
        chk("mr_no_rvalid", rvalid, 0);
        req = 4'b1111;
        step;
        chk("ptr_rst_gnt", gnt, 4'b0001);
        req = 4'b1010;
        step; step;
        for (int j = 0; j < 4; j++) begin
            step;
            id = fp ? 1 : (j % 2 ? 3 : 1);
            eg = 4'b0001 << id;
            chk("pri_gnt", gnt, eg);
            step; step;
            chk("pri_rid", rid, id);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rom_1p_arb.md
Name: rom_1p_arb

Overview:
- Round-robin arbiter and read sequencer that shares one single-port ROM instance among Req_Num requesters.
- Drives the ROM's low-active chip enable, output enable and address, captures the 1-cycle-latency read data, and returns it with the winner's ID over a valid/ready handshake.
- Sits between encoder sub-modules that read constant tables (e.g. scan/quant tables) and the shared ROM macro.

Parameters:
- Word_Width, 32, ROM data width
- Addr_Width, 8, ROM address width
- Req_Num, 4, number of requesters (2..8)
- Id_Width, 2, requester ID width; must equal ceil(log2(Req_Num))

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous reset, active low
- req_i  input  Req_Num  per-requester read request; held with address until granted
- addr_i  input  Req_Num*Addr_Width  packed addresses; requester k uses bits [k*Addr_Width +: Addr_Width]
- gnt_o  output  Req_Num  one-hot, registered, 1-cycle pulse when request k is accepted
- rdata_o  output  Word_Width  read data, registered
- rid_o  output  Id_Width  ID of the requester owning rdata_o
- rvalid_o  output  1  rdata_o/rid_o valid
- rready_i  input  1  consumer accepts data when rvalid_o and rready_i are both high
- rom_cen_o  output  1  ROM chip enable, low active
- rom_oen_o  output  1  ROM output enable, low active
- rom_addr_o  output  Addr_Width  ROM address
- rom_data_i  input  Word_Width  ROM data; valid the cycle after rom_cen_o is low, held while cen is high

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, rid_o=0, rom_cen_o=1, rom_oen_o=1, rom_addr_o=0, RR pointer=Req_Num-1.
- After reset, rom_oen_o=0 permanently.
- State machine:
  - IDLE: if any req_i, arbitrate combinationally and go to RD; otherwise stay.
  - RD, 1 cycle: rom_cen_o=0, rom_addr_o=winner's address, gnt_o[winner]=1, pointer<=winner. Next state WT.
  - WT, 1 cycle: rom_cen_o=1. Capture rom_data_i into rdata_o and the winner ID into rid_o at end of cycle. Next state VLD.
  - VLD: rvalid_o=1; rdata_o and rid_o stable.
    - rready_i=0: stay.
    - rready_i=1 with any req_i: arbitrate and go to RD.
    - rready_i=1 with no req_i: go to IDLE.
- All outputs are registered. rom_cen_o, rom_addr_o and gnt_o are loaded on the transition into RD.
- Latency: req_i sampled high in cycle T (IDLE) -> gnt_o and rom_cen_o low in T+1 -> rvalid_o in T+3.
- Peak throughput: one read per 3 cycles with rready_i tied high.
- Round-robin: search starts at pointer+1 and wraps modulo Req_Num. The first asserted req_i wins.
- Exactly one grant per read. Never more than one bit of gnt_o is high.
- A requester must drop req_i (or present a new address) the cycle after its gnt_o. A req_i still high after gnt_o is treated as a new request.
- req_i deasserted before grant: that request is dropped silently. No error.
- All req_i high continuously: grants rotate 0,1,2,3,0,... No starvation; maximum wait is Req_Num-1 reads.
- rready_i high outside VLD: ignored.
- rst_n low in any state: immediate return to reset values at that edge. An in-flight read is discarded and no rvalid_o is produced for it.
- ROM is never enabled (rom_cen_o=0) in any state other than RD.

Optional Feature:
- Macro ROM_1P_ARB_FIXED_PRI_EN.
- Defined: fixed priority; lowest index with req_i high always wins. The pointer is not used and is not updated.
- Undefined: round-robin as above.
- Interface and timing are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_i=4'b1111 -> gnt_o=0, rvalid_o=0, rom_cen_o=1, rom_oen_o=1. Release -> first grant to requester 0.
- Single read: ROM preloaded mem[0x3C]=0xDEADBEEF; req_i[2]=1, addr=0x3C at T:
  - T+1: gnt_o=4'b0100, rom_cen_o=0, rom_addr_o=0x3C.
  - T+3: rvalid_o=1, rdata_o=0xDEADBEEF, rid_o=2.
- Round-robin: req_i=4'b1111 held, rready_i=1, addresses 0x10..0x13 -> grant order 0,1,2,3,0, one grant every 3 cycles, each rdata_o matching mem[addr] and rid_o.
- Backpressure: rready_i=0 for 5 cycles in VLD -> rvalid_o, rdata_o and rid_o stable, no further gnt_o, rom_cen_o=1. rready_i=1 -> next grant the following cycle.
- Reset mid-read: rst_n=0 in WT -> no rvalid_o for that read; state IDLE, pointer reset.
- ROM_1P_ARB_FIXED_PRI_EN defined: req_i=4'b1010 held -> requester 1 granted repeatedly and requester 3 never granted while req_i[1] stays high.
